// File: rtl/key_matrix_scan.sv
// 4x4 keypad scanner: rotates an active-low row drive, debounces press and release
// of the first key found, and reports its code with a one-clock valid strobe.
module key_matrix_scan #(
    parameter int SCAN_DIV = 25000,
    parameter int DEB_CNT  = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_v,
    output logic [3:0] key_h,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        DEB_P = 2'd1,
        HELD  = 2'd2,
        DEB_R = 2'd3
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
    localparam logic [7:0]  DEB_MAX  = 8'(DEB_CNT);

    logic [3:0]  sync1_q, sync2_q;
    logic [15:0] div_q;
    state_t      state_q, state_d;
    logic [1:0]  row_q, row_d;
    logic [3:0]  key_h_q, key_h_d;
    logic [1:0]  cap_col_q, cap_col_d;
    logic [7:0]  deb_q, deb_d;
    logic [3:0]  code_q, code_d;
    logic        valid_q, valid_d;
    logic        down_q, down_d;

    logic [3:0]  col;
    logic        tick;
    logic        cap_open;
    logic [7:0]  deb_next;

    function automatic logic [1:0] lowest_zero(input logic [3:0] c);
        if (!c[0])      return 2'd0;
        else if (!c[1]) return 2'd1;
        else if (!c[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    function automatic logic [3:0] row_drive(input logic [1:0] r);
        return ~(4'b0001 << r);
    endfunction

    function automatic logic [7:0] deb_inc(input logic [7:0] d);
        return (d >= DEB_MAX) ? DEB_MAX : d + 8'd1;
    endfunction

    assign col      = sync2_q;
    assign tick     = (div_q == DIV_LAST);
    assign cap_open = col[cap_col_q];
    assign deb_next = deb_inc(deb_q);

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        cap_col_d = cap_col_q;
        deb_d     = deb_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        down_d    = down_q;

        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (col == 4'b1111) begin
                        row_d = row_q + 2'd1;
                    end else begin
                        cap_col_d = lowest_zero(col);
                        deb_d     = 8'd1;
                        state_d   = DEB_P;
                    end
                end
                DEB_P: begin
                    if (!cap_open) begin
                        deb_d = deb_next;
                        if (deb_next == DEB_MAX) begin
                            code_d  = {row_q, cap_col_q};
                            valid_d = 1'b1;
                            down_d  = 1'b1;
                            state_d = HELD;
                        end
                    end else begin
                        // Bounce on press: drop the candidate and keep scanning.
                        deb_d   = 8'd0;
                        row_d   = row_q + 2'd1;
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (cap_open) begin
                        deb_d   = 8'd1;
                        state_d = DEB_R;
                    end
                end
                DEB_R: begin
                    if (cap_open) begin
                        deb_d = deb_next;
                        if (deb_next == DEB_MAX) begin
                            down_d  = 1'b0;
                            deb_d   = 8'd0;
                            row_d   = row_q + 2'd1;
                            state_d = SCAN;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    assign key_h_d = row_drive(row_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 4'hF;
            sync2_q   <= 4'hF;
            div_q     <= '0;
            state_q   <= SCAN;
            row_q     <= '0;
            key_h_q   <= 4'b1110;
            cap_col_q <= '0;
            deb_q     <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            down_q    <= 1'b0;
        end else begin
            sync1_q   <= key_v;
            sync2_q   <= sync1_q;
            div_q     <= tick ? 16'd0 : div_q + 16'd1;
            state_q   <= state_d;
            row_q     <= row_d;
            key_h_q   <= key_h_d;
            cap_col_q <= cap_col_d;
            deb_q     <= deb_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            down_q    <= down_d;
        end
    end

    assign key_h     = key_h_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_down  = down_q;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Bench for key_matrix_scan: keypad model plus a tick-level run-length reference model,
// directed scenarios followed by randomized key activity.
module tb_key_matrix_scan;

    localparam int SCAN_DIV = 4;
    localparam int DEB_CNT  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key_v;
    logic [3:0]  key_h;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] pressed = '0;

    int n_checks = 0;
    int n_err    = 0;
    int pulses   = 0;

    // Reference model: scanned row, tracked key, and consecutive-agreement run length.
    int         m_row;
    int         m_col;
    bit         m_track;
    bit         m_acc;
    int         m_run;
    logic [3:0] exp_code;
    logic       exp_down;
    logic       exp_valid;

    key_matrix_scan #(.SCAN_DIV(SCAN_DIV), .DEB_CNT(DEB_CNT)) dut (
        .clk      (clk),
        .rst      (rst),
        .key_v    (key_v),
        .key_h    (key_h),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_down (key_down)
    );

    always #5 clk = ~clk;

    always_comb begin
        key_v = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !key_h[r]) key_v[c] = 1'b0;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_row     = 0;
        m_col     = 0;
        m_track   = 0;
        m_acc     = 0;
        m_run     = 0;
        exp_code  = 4'd0;
        exp_down  = 1'b0;
        exp_valid = 1'b0;
    endtask

    task automatic model_tick();
        bit down;
        exp_valid = 1'b0;
        if (!m_track) begin
            m_col = -1;
            for (int c = 3; c >= 0; c--)
                if (pressed[m_row*4+c]) m_col = c;
            if (m_col < 0) begin
                m_row = (m_row + 1) % 4;
            end else begin
                m_track = 1;
                m_acc   = 0;
                m_run   = 1;
            end
        end else begin
            down = pressed[m_row*4+m_col];
            if (!m_acc) begin
                if (down) begin
                    m_run++;
                    if (m_run == DEB_CNT) begin
                        m_acc     = 1;
                        m_run     = 0;
                        exp_code  = 4'(m_row*4 + m_col);
                        exp_down  = 1'b1;
                        exp_valid = 1'b1;
                    end
                end else begin
                    m_track = 0;
                    m_row   = (m_row + 1) % 4;
                end
            end else begin
                if (down) begin
                    m_run = 0;
                end else begin
                    m_run++;
                    if (m_run == DEB_CNT) begin
                        exp_down = 1'b0;
                        m_track  = 0;
                        m_row    = (m_row + 1) % 4;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One scan tick: three quiet clocks, then the tick edge compared against the model.
    task automatic step();
        for (int k = 0; k < SCAN_DIV; k++) begin
            @(posedge clk);
            #1;
            if (k < SCAN_DIV - 1) chk("valid_gap", {3'b000, key_valid}, 4'd0);
        end
        model_tick();
        chk("key_h", key_h, 4'hF ^ 4'(1 << m_row));
        chk("key_code", key_code, exp_code);
        chk("key_valid", {3'b000, key_valid}, {3'b000, exp_valid});
        chk("key_down", {3'b000, key_down}, {3'b000, exp_down});
        if (key_valid === 1'b1) pulses++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_row(input int r);
        for (int i = 0; i < 8 && m_row != r; i++) step();
        chk("row_reach", key_h, 4'hF ^ 4'(1 << r));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_h"}, key_h, 4'b1110);
        chk({tag, "_code"}, key_code, 4'd0);
        chk({tag, "_valid"}, {3'b000, key_valid}, 4'd0);
        chk({tag, "_down"}, {3'b000, key_down}, 4'd0);
    endtask

    initial begin
        rst = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #2;
        chk_reset_outputs("rst");
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst_hold");
        @(negedge clk) rst = 1'b0;

        // Idle rotation.
        steps(5);

        // Clean press of (2,1) and release.
        pulses = 0;
        pressed[2*4+1] = 1'b1;
        steps(10);
        chk("press_code", key_code, 4'd9);
        chk("press_down", {3'b000, key_down}, 4'd1);
        chk("press_pulses", 4'(pulses), 4'd1);
        pressed = '0;
        steps(3);
        chk("rel_down", {3'b000, key_down}, 4'd0);
        chk("rel_row", key_h, 4'b0111);

        // Press bounce on (1,3).
        wait_row(1);
        pulses = 0;
        pressed[1*4+3] = 1'b1;
        step();
        pressed = '0;
        step();
        chk("pbounce_h", key_h, 4'b1011);
        chk("pbounce_down", {3'b000, key_down}, 4'd0);
        chk("pbounce_pulses", 4'(pulses), 4'd0);

        // Release bounce on (2,1).
        pulses = 0;
        pressed[2*4+1] = 1'b1;
        steps(10);
        pressed = '0;
        step();
        pressed[2*4+1] = 1'b1;
        steps(3);
        chk("rbounce_down", {3'b000, key_down}, 4'd1);
        chk("rbounce_pulses", 4'(pulses), 4'd1);
        pressed = '0;
        steps(3);
        chk("rbounce_rel", {3'b000, key_down}, 4'd0);

        // Multi-key in row 0, then an extra key elsewhere while held.
        pulses = 0;
        pressed[0*4+2] = 1'b1;
        pressed[0*4+0] = 1'b1;
        steps(10);
        chk("multi_code", key_code, 4'd0);
        chk("multi_pulses", 4'(pulses), 4'd1);
        pressed[3*4+3] = 1'b1;
        steps(5);
        chk("multi_ign_code", key_code, 4'd0);
        chk("multi_ign_pulses", 4'(pulses), 4'd1);
        chk("multi_ign_down", {3'b000, key_down}, 4'd1);
        pressed = '0;
        steps(4);
        chk("multi_rel", {3'b000, key_down}, 4'd0);

        // Asynchronous reset while (2,1) is held.
        pressed[2*4+1] = 1'b1;
        steps(10);
        chk("midrst_pre", {3'b000, key_down}, 4'd1);
        #7 rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("midrst_hold");
        @(negedge clk) rst = 1'b0;
        pulses = 0;
        steps(10);
        chk("midrst_code", key_code, 4'd9);
        chk("midrst_pulses", 4'(pulses), 4'd1);
        pressed = '0;
        steps(4);

        // Randomized key activity, changes aligned to tick boundaries.
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                int n;
                pressed = '0;
                n = int'($urandom_range(0, 2));
                for (int i = 0; i < n; i++) pressed[$urandom_range(0, 15)] = 1'b1;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
